lsu_rmw: RTL and testbench
==========================

Name: lsu_rmw

Overview:
- Load/store unit between the CPU execute stage and the DmemPort of the unified block-RAM memory. The memory has a 1-cycle synchronous read and whole-word writes.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Loads: byte-lane extraction plus sign/zero extension. Sub-word stores: read-modify-write.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_LSB, 2, word-address shift; byte lane = addr[1:0].

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code
- req_addr  in  WORD_LEN  byte address
- req_wdata  in  WORD_LEN  store data; data in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  WORD_LEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- mem_addr  out  WORD_LEN  to memory addr_d
- mem_rdata  in  WORD_LEN  from memory rdata; valid 1 cycle after address
- mem_wen  out  1  to memory wen
- mem_wdata  out  WORD_LEN  to memory wdata

Behaviour:
- Reset: state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0. Captured addr/funct3/wdata registers = 0. mem_wen is forced 0 while rst is high.
- Reset mid-operation aborts the operation. No partial write occurs after reset asserts.
- States: IDLE, LD_WAIT, ST_MERGE, RESP. req_ready = (state == IDLE).
- Accept: req_valid && req_ready. On accept, capture addr, funct3 and wdata.
- mem_addr = req_addr in IDLE, else the captured address. Low 2 bits are passed through; memory ignores them.
- Legality:
  - funct3 000/100 is always aligned.
  - 001/101 requires addr[0] = 0.
  - 010 requires addr[1:0] = 0.
  - Stores accept only 000/001/010. All other codes are illegal.
- Illegal accept: mem_wen = 0. IDLE -> RESP with resp_err = 1, resp_rdata = 0.
- Load accept, cycle T: IDLE -> LD_WAIT. At T+1, mem_rdata is used as follows:
  - Lane select: byte = addr[1:0]*8, half = addr[1]*16.
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Register into resp_rdata. Go to RESP; resp_valid = 1 in cycle T+2.
- SW accept at T: mem_wen = 1 and mem_wdata = req_wdata combinationally in T, so the memory writes at the end of T. IDLE -> RESP; resp_valid in T+1.
- SB/SH accept at T: mem_wen = 0 (memory reads). IDLE -> ST_MERGE.
- ST_MERGE (T+1):
  - mem_wdata = mem_rdata with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
  - mem_wen = 1. Go to RESP; resp_valid in T+2.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. Outside RESP, resp_valid = 0. resp_rdata/resp_err hold until the next RESP.
- mem_wen = 0 in LD_WAIT and RESP. mem_wdata = req_wdata whenever it is not a merge cycle.
- Throughput: one request per 2 cycles (SW, error) or 3 cycles (loads, SB/SH). No back-to-back accept from RESP.
- req_valid while not ready is ignored. The CPU holds the request until it sees req_ready.

Decomposition:
- consts.vh (shared): WORD_LEN, funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW), LSU state encodings.
- Sub-module lsu_align (combinational): load extraction/extension, store lane merge, legality check. lsu_rmw holds the FSM and registers.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB addr 0x11 -> resp_rdata 0xFFFFFFAA in T+2, resp_err 0. LBU addr 0x13 -> 0x00000088.
- LH addr 0x12 -> 0xFFFF8899. LHU addr 0x10 -> 0x0000AABB. LW addr 0x10 -> 0x8899AABB.
- SB addr 0x12, wdata 0x123456CC -> mem_wen only in T+1, mem_wdata 0x88CCAABB. Subsequent LW 0x10 returns 0x88CCAABB.
- SW addr 0x20, wdata 0xDEADBEEF -> mem_wen in accept cycle, resp_valid T+1. SH addr 0x22, wdata 0x1234, then LW 0x20 -> 0x1234BEEF.
- LW addr 0x21, SH addr 0x23, funct3 011 -> resp_err 1, resp_rdata 0, mem_wen never asserted, memory unchanged.
- Assert rst during ST_MERGE of SB -> mem_wen 0, state IDLE, resp_valid 0, target word unchanged. Next request completes normally.

Source files
------------

// File: rtl/lsu_rmw_pkg.sv
// Shared constants for the load/store unit: word size, RV32I funct3 codes,
// FSM state encodings and the access legality rule.
package lsu_rmw_pkg;

    localparam int WORD_LEN = 32;
    localparam int ADDR_LSB = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LD_WAIT = 2'd1;
    localparam logic [1:0] ST_MERGE   = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef struct packed {
        logic [WORD_LEN-1:0] addr;
        logic [2:0]          funct3;
        logic [WORD_LEN-1:0] wdata;
    } lsu_req_t;

    // Stores have no unsigned variants, so 100/101 are legal only for loads.
    function automatic logic is_legal(input logic wen, input logic [2:0] f3,
                                      input logic [ADDR_LSB-1:0] lane);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lane[0];
            3'b010:  ok = (lane == '0);
            3'b100:  ok = ~wen;
            3'b101:  ok = ~wen & ~lane[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: load lane extraction with sign/zero
// extension, sub-word store merge into the read word, and the legality check.
module lsu_align
    import lsu_rmw_pkg::*;
(
    input  logic                wen,
    input  logic [2:0]          funct3,
    input  logic [ADDR_LSB-1:0] lane,
    input  logic [WORD_LEN-1:0] rdata,
    input  logic [WORD_LEN-1:0] wdata,
    output logic                legal,
    output logic [WORD_LEN-1:0] load_data,
    output logic [WORD_LEN-1:0] merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [4:0]  byte_shift;

    assign legal      = is_legal(wen, funct3, lane);
    assign byte_shift = {lane, 3'b000};

    always_comb begin
        sel_byte  = rdata[byte_shift +: 8];
        sel_half  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'd0, sel_byte};
            F3_LHU:  load_data = {16'd0, sel_half};
            default: load_data = '0;
        endcase
    end

    // Only the addressed lane(s) change; the rest of the word is written back as read.
    always_comb begin
        merge_data = rdata;
        case (funct3)
            F3_SB:   merge_data[byte_shift +: 8] = wdata[7:0];
            F3_SH: begin
                if (lane[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a 1-cycle synchronous block RAM with whole-word
// writes: loads take a wait cycle, sub-word stores do read-modify-write.
module lsu_rmw
    import lsu_rmw_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata
);

    logic [1:0]          state;
    lsu_req_t            cap;
    logic                idle;
    logic                accept;
    logic                is_sw;
    logic [2:0]          cur_funct3;
    logic [WORD_LEN-1:0] cur_wdata;
    logic                legal;
    logic [WORD_LEN-1:0] load_data;
    logic [WORD_LEN-1:0] merge_data;

    assign idle       = (state == ST_IDLE);
    assign req_ready  = idle;
    assign accept     = req_valid && idle;
    assign is_sw      = req_wen && (req_funct3 == F3_SW);
    assign resp_valid = (state == ST_RESP);

    // In IDLE the live request drives the memory and the legality check;
    // afterwards the captured copy keeps address and lane stable.
    assign mem_addr   = idle ? req_addr   : cap.addr;
    assign cur_funct3 = idle ? req_funct3 : cap.funct3;
    assign cur_wdata  = idle ? req_wdata  : cap.wdata;

    lsu_align u_align (
        .wen        (req_wen),
        .funct3     (cur_funct3),
        .lane       (mem_addr[ADDR_LSB-1:0]),
        .rdata      (mem_rdata),
        .wdata      (cur_wdata),
        .legal      (legal),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Gating with rst keeps a merge cut short by reset from reaching the RAM.
    assign mem_wen   = ~rst && ((accept && legal && is_sw) || (state == ST_MERGE));
    assign mem_wdata = (state == ST_MERGE) ? merge_data : req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cap        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap.addr   <= req_addr;
                        cap.funct3 <= req_funct3;
                        cap.wdata  <= req_wdata;
                        if (!legal) begin
                            state      <= ST_RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_wen) begin
                            state <= ST_LD_WAIT;
                        end else if (is_sw) begin
                            state      <= ST_RESP;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                        end else begin
                            state <= ST_MERGE;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    state      <= ST_RESP;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                end
                ST_MERGE: begin
                    state      <= ST_RESP;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: behavioural block RAM, response scoreboard
// with latency tracking, and per-cycle checks of the memory write strobe.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_wdata;

    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    lsu_rmw dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model: registered read, whole-word write.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:2]];
        if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                checkOutput("resp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Drives one request and checks mem_wen (and mem_wdata when writing) over
    // the accept cycle and the two following cycles.
    task automatic applyStimulus(input logic wen, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input logic [2:0] wen_mask,
                                 input logic [31:0] exp_wdata);
        int n;
        exp_t e;
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) checkOutput("ready_timeout", 32'd0, 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cyc;
        e.lat   = exp_lat;
        sb.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mem_wen_c%0d", k), {31'd0, mem_wen}, {31'd0, wen_mask[k]});
            if (wen_mask[k]) checkOutput($sformatf("mem_wdata_c%0d", k), mem_wdata, exp_wdata);
            @(posedge clk); #1;
            if (k == 0) req_valid = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4]     = 32'h8899AABB;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Loads from the preloaded word 0x8899AABB
        applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 3'b000, 32'h0);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 3'b000, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 3'b000, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 3'b000, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 3'b000, 32'h0);

        // Byte store with read-modify-write, then read back
        applyStimulus(1'b1, 3'b000, 32'h12, 32'h123456CC, 32'h0, 1'b0, 2, 3'b010, 32'h88CCAABB);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'h88CCAABB, 1'b0, 2, 3'b000, 32'h0);

        // Word store, upper-half store, read back
        applyStimulus(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1, 3'b001, 32'hDEADBEEF);
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h00001234, 32'h0, 1'b0, 2, 3'b010, 32'h1234BEEF);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234BEEF, 1'b0, 2, 3'b000, 32'h0);

        // Misaligned and illegal accesses never write
        applyStimulus(1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 1, 3'b000, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h23, 32'h5555AAAA, 32'h0, 1'b1, 1, 3'b000, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 3'b000, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h20, 32'h000000FF, 32'h0, 1'b1, 1, 3'b000, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'h22, 32'hCAFEF00D, 32'h0, 1'b1, 1, 3'b000, 32'h0);
        checkOutput("mem_after_illegal", mem[8], 32'h1234BEEF);

        // Reset asserted while the byte store sits in its merge cycle
        req_valid  = 1'b1;
        req_wen    = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h00000077;
        @(negedge clk);
        checkOutput("abort_accept_wen", {31'd0, mem_wen}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_mem_word", mem[8], 32'h1234BEEF);
        applyStimulus(1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 3'b000, 32'h0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
